// File: rtl/oled_line_scheduler_pkg.sv
// oled_sched_pkg: shared types and ASCII constants for the OLED line scheduler.
package oled_sched_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_SEND} state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_MIN   = 8'h20;
    localparam logic [7:0] ASCII_MAX   = 8'h7E;

    function automatic logic [7:0] printable(input logic [7:0] b);
        return (b < ASCII_MIN || b > ASCII_MAX) ? ASCII_SPACE : b;
    endfunction

endpackage

// File: rtl/oled_line_scheduler_if.sv
// oled_line_scheduler_if: byte channel between the scheduler and oledControl.
interface oled_line_scheduler_if;
    logic [7:0] send_data;
    logic       send_data_valid;
    logic       send_done;
    modport master (output send_data, send_data_valid, input send_done);
    modport slave  (input send_data, send_data_valid, output send_done);
endinterface

// File: rtl/oled_line_scheduler_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant; pointer moves past the winner on advance.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    input  logic         advance
);
    localparam int W = N > 1 ? $clog2(N) : 1;
    logic [W-1:0] ptr_q, ptr_d, j;
    always_comb begin
        grant = '0;
        ptr_d = ptr_q;
        j     = '0;
        // Descending scan so the request closest to the pointer wins.
        for (int k = N - 1; k >= 0; k--) begin
            j = W'((int'(ptr_q) + k) % N);
            if (req[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                ptr_d    = W'((int'(j) + 1) % N);
            end
        end
    end
    always_ff @(posedge clock) begin
        if (reset) ptr_q <= '0;
        else if (advance) ptr_q <= ptr_d;
    end
endmodule

// File: rtl/oled_line_scheduler.sv
// oled_line_scheduler: frame buffer fed by round-robin line writes, streamed to oledControl.
// Define OLED_SCHED_PRINTABLE_EN to store non-printable bytes as spaces.
module oled_line_scheduler
    import oled_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int LINE_CHARS = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*LINE_CHARS*8-1:0] req_line,
    output logic [NUM_REQ-1:0]              req_ack,
    oled_line_scheduler_if.master           oled,
    output logic                            frame_busy,
    output logic                            frame_pending
);
    localparam int FRAME = NUM_REQ * LINE_CHARS;
    localparam int IW    = FRAME > 1 ? $clog2(FRAME) : 1;

    function automatic logic [LINE_CHARS*8-1:0] cap(input logic [LINE_CHARS*8-1:0] l);
        cap = l;
`ifdef OLED_SCHED_PRINTABLE_EN
        for (int c = 0; c < LINE_CHARS; c++) cap[c*8 +: 8] = printable(l[c*8 +: 8]);
`else
`endif
    endfunction

    // Byte k of the frame lives at bits [(FRAME-1-k)*8 +: 8], so line 0 char 0 is the MSB.
    logic [FRAME*8-1:0] buf_q;
    logic [NUM_REQ-1:0] grant, ack_q;
    logic               wr;
    state_e             state_q, state_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d, pend_q, pend_d;

    // A line being acked this cycle is masked so a held request is not granted twice.
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (req_valid & ~ack_q),
        .grant   (grant),
        .advance (wr)
    );
    assign wr = |grant;

    always_ff @(posedge clock) begin
        if (reset) begin
            ack_q <= '0;
            buf_q <= {FRAME{ASCII_SPACE}};
        end else begin
            ack_q <= grant;
            for (int i = 0; i < NUM_REQ; i++)
                if (grant[i])
                    buf_q[(NUM_REQ-1-i)*LINE_CHARS*8 +: LINE_CHARS*8] <= cap(req_line[i*LINE_CHARS*8 +: LINE_CHARS*8]);
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        pend_d  = pend_q;
        case (state_q)
            S_IDLE: if (pend_q) begin
                pend_d  = 1'b0;
                idx_d   = '0;
                state_d = S_ISSUE;
            end
            S_ISSUE: if (!oled.send_done) begin
                data_d  = buf_q[(FRAME-1-int'(idx_q))*8 +: 8];
                valid_d = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: if (oled.send_done) begin
                valid_d = 1'b0;
                state_d = (idx_q == IW'(FRAME - 1)) ? S_IDLE : S_ISSUE;
                idx_d   = (idx_q == IW'(FRAME - 1)) ? idx_q : idx_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // A write wins over the idle-state clear so the update is never lost.
        if (wr) pend_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
        end
    end

    assign req_ack              = ack_q;
    assign oled.send_data       = data_q;
    assign oled.send_data_valid = valid_q;
    assign frame_busy           = state_q != S_IDLE;
    assign frame_pending        = pend_q;
endmodule

// File: tb/tb_oled_line_scheduler.sv
// tb_oled_line_scheduler: directed bench with an oledControl responder and byte capture.
module tb_oled_line_scheduler;
    localparam int N  = 4;
    localparam int LC = 16;
    localparam int FR = N * LC;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [N-1:0]      req_valid = '0;
    logic [N*LC*8-1:0] req_line = '0;
    logic [N-1:0]      req_ack;
    logic              frame_busy, frame_pending;

    oled_line_scheduler_if oled ();

    oled_line_scheduler #(.NUM_REQ(N), .LINE_CHARS(LC)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_line      (req_line),
        .req_ack       (req_ack),
        .oled          (oled),
        .frame_busy    (frame_busy),
        .frame_pending (frame_pending)
    );

    always #5 clock = ~clock;

    int         checks = 0, failures = 0;
    logic [7:0] got[$];
    logic [7:0] exp_buf[FR];
    int         extra_hold = 0, hold_left = 0, cnt = 0;
    int         viol_stab = 0, viol_done = 0, gap = 0, max_gap = 0;
    logic       pv = 1'b0;
    logic [7:0] pd = '0;

    // oledControl model: raises send_done on the third negedge of valid, holds it
    // extra_hold cycles after valid drops; also logs bytes and handshake violations.
    always @(negedge clock) begin
        if (reset) begin
            oled.send_done = 1'b0;
            cnt = 0; hold_left = 0; pv = 1'b0; gap = 0;
        end else begin
            if (oled.send_data_valid && !pv) begin
                got.push_back(oled.send_data);
                if (oled.send_done) viol_done++;
                if (gap > max_gap) max_gap = gap;
            end
            if (oled.send_data_valid && pv && oled.send_data !== pd) viol_stab++;
            gap = oled.send_data_valid ? 0 : gap + 1;
            pv = oled.send_data_valid;
            pd = oled.send_data;
            if (oled.send_done) begin
                if (!oled.send_data_valid) begin
                    if (hold_left > 0) hold_left--;
                    else oled.send_done = 1'b0;
                end
            end else if (oled.send_data_valid) begin
                if (cnt == 2) begin
                    oled.send_done = 1'b1; cnt = 0; hold_left = extra_hold;
                end else cnt++;
            end
        end
    end

    function automatic logic [7:0] filt(input logic [7:0] b);
`ifdef OLED_SCHED_PRINTABLE_EN
        return (b < 8'h20 || b > 8'h7E) ? 8'h20 : b;
`else
        return b;
`endif
    endfunction

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_exp;
        for (int k = 0; k < FR; k++) exp_buf[k] = 8'h20;
    endtask

    task automatic set_line(input int i, input logic [LC*8-1:0] line);
        req_line[i*LC*8 +: LC*8] = line;
        for (int c = 0; c < LC; c++) exp_buf[i*LC+c] = filt(line[(LC-1-c)*8 +: 8]);
    endtask

    task automatic request(input int i, input logic [LC*8-1:0] line);
        int t;
        t = 0;
        set_line(i, line);
        req_valid[i] = 1'b1;
        do begin tick; t++; end while (!req_ack[i] && t < 20);
        chk($sformatf("ack_req%0d", i), 32'(req_ack), 32'(1 << i));
        req_valid[i] = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while ((frame_busy || frame_pending) && t < 5000) begin tick; t++; end
        chk(tag, 32'(t < 5000), 32'd1);
    endtask

    task automatic wait_got(input int n);
        int t;
        t = 0;
        while (got.size() < n && t < 2000) begin tick; t++; end
        chk($sformatf("wait_bytes%0d", n), 32'(got.size() >= n), 32'd1);
    endtask

    function automatic int frame_errs(input int base);
        int e;
        if (base < 0 || got.size() < base + FR) return 999;
        e = 0;
        for (int k = 0; k < FR; k++) if (got[base+k] !== exp_buf[k]) e++;
        return e;
    endfunction

    initial begin
        int bad, n;
        logic [7:0] ch;
        logic [LC*8-1:0] l6;

        repeat (3) tick;
        chk("rst_ack", 32'(req_ack), 32'd0);
        chk("rst_valid", 32'(oled.send_data_valid), 32'd0);
        chk("rst_data", 32'(oled.send_data), 32'd0);
        chk("rst_busy", 32'(frame_busy), 32'd0);
        chk("rst_pending", 32'(frame_pending), 32'd0);
        reset = 1'b0;
        clear_exp;

        bad = 0;
        repeat (100) begin tick; if (oled.send_data_valid || frame_busy) bad++; end
        chk("idle_quiet", 32'(bad), 32'd0);

        request(0, "HELLO WORLD     ");
        tick;
        chk("ack_one_cycle", 32'(req_ack), 32'd0);
        tick;
        chk("first_byte_latency", 32'(oled.send_data_valid), 32'd1);
        drain("drain_hello");
        chk("hello_count", 32'(got.size()), 32'd64);
        chk("hello_bytes", 32'(frame_errs(0)), 32'd0);
        chk("hello_busy_end", 32'(frame_busy), 32'd0);

        reset = 1'b1; tick; reset = 1'b0;
        clear_exp;
        got.delete();
        for (int i = 0; i < N; i++) begin
            ch = 8'(8'h41 + i);
            set_line(i, {LC{ch}});
        end
        req_valid = '1;
        for (int k = 0; k < 8; k++) begin
            tick;
            chk($sformatf("rr_ack%0d", k), 32'(req_ack), 32'(1 << (k % N)));
        end
        req_valid = '0;
        drain("drain_rr");
        chk("rr_last_frame", 32'(frame_errs(got.size() - FR)), 32'd0);

        got.delete();
        request(1, "line one is here");
        wait_got(6);
        request(2, "NEW LINE TWO 222");
        drain("drain_tear");
        chk("tear_count", 32'(got.size()), 32'd128);
        chk("tear_second_frame", 32'(frame_errs(FR)), 32'd0);

        got.delete();
        request(3, "third line hold!");
        wait_got(3);
        max_gap = 0;
        extra_hold = 10;
        wait_got(4);
        extra_hold = 0;
        wait_got(5);
        chk("hold_gap", 32'(max_gap >= 10), 32'd1);
        drain("drain_hold");
        chk("hold_count", 32'(got.size()), 32'd64);
        chk("hold_bytes", 32'(frame_errs(0)), 32'd0);
        chk("no_valid_while_done", 32'(viol_done), 32'd0);
        chk("data_stable", 32'(viol_stab), 32'd0);

        got.delete();
        request(0, "RESET TEST LINE!");
        wait_got(21);
        reset = 1'b1;
        tick;
        chk("midrst_valid", 32'(oled.send_data_valid), 32'd0);
        chk("midrst_busy", 32'(frame_busy), 32'd0);
        reset = 1'b0;
        clear_exp;
        n = got.size();
        repeat (50) tick;
        chk("midrst_no_stream", 32'(got.size()), 32'(n));
        got.delete();
        l6 = {"AB", 8'h0A, 8'h7F, "CDEFGHIJKLMN"};
        request(1, l6);
        drain("drain_post_reset");
        chk("post_reset_count", 32'(got.size()), 32'd64);
        chk("post_reset_bytes", 32'(frame_errs(0)), 32'd0);
        if (got.size() >= 20) begin
            chk("nonprint_0a", 32'(got[18]), 32'(filt(8'h0A)));
            chk("nonprint_7f", 32'(got[19]), 32'(filt(8'h7F)));
        end else begin
            chk("nonprint_len", 32'(got.size()), 32'd64);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
